prio_arbiter: RTL and testbench

PRIO_ARBITER -- requirements
Module: prio_arbiter

---
 rtl/prio_arbiter_pkg.sv | 14 +
 rtl/prio_find.sv | 31 +++
 rtl/prio_arbiter.sv | 99 +++++++++
 tb/tb_prio_arbiter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/prio_arbiter_pkg.sv
// Shared types and helpers for the request arbiter.
package prio_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Width of an encoded index into n request lines (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prio_find.sv
// Wrapped lowest-index search: first set bit of vec_i at or after start_i, wrapping at N.
module prio_find #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     vec_i,
    input  logic [IDX_W-1:0] start_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    int pos;

    // Scan farthest-first so the nearest hit from start_i is the last one written.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        pos     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = int'(start_i) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (vec_i[pos[IDX_W-1:0]]) begin
                found_o = 1'b1;
                idx_o   = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/prio_arbiter.sv
// Request arbiter with a valid/ready grant port; fixed priority by default,
// round-robin when PRIO_ARBITER_RR_EN is defined.
module prio_arbiter
    import prio_arbiter_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = idx_width(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    output logic             gnt_valid,
    input  logic             gnt_ready,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [N-1:0]     gnt_onehot
);

    state_e           state_q;
    logic             valid_q;
    logic [IDX_W-1:0] idx_q;
    logic [N-1:0]     onehot_q;

    logic [IDX_W-1:0] search_start;
    logic             win_found_d;
    logic [IDX_W-1:0] win_idx_d;
    logic [N-1:0]     win_onehot_d;

`ifdef PRIO_ARBITER_RR_EN
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] last_idx;

    // On a handshake the grant being accepted becomes the new "last", so search past it.
    always_comb begin
        last_idx     = (state_q == GRANT) ? idx_q : ptr_q;
        search_start = (last_idx == IDX_W'(N - 1)) ? '0 : last_idx + 1'b1;
    end
`else
    assign search_start = '0;
`endif

    prio_find #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_find (
        .vec_i   (req),
        .start_i (search_start),
        .found_o (win_found_d),
        .idx_o   (win_idx_d)
    );

    always_comb begin
        win_onehot_d            = '0;
        win_onehot_d[win_idx_d] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            onehot_q <= '0;
`ifdef PRIO_ARBITER_RR_EN
            ptr_q    <= IDX_W'(N - 1);
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_found_d) begin
                        state_q  <= GRANT;
                        valid_q  <= 1'b1;
                        idx_q    <= win_idx_d;
                        onehot_q <= win_onehot_d;
                    end
                end
                GRANT: begin
                    if (gnt_ready) begin
`ifdef PRIO_ARBITER_RR_EN
                        ptr_q <= idx_q;
`endif
                        if (win_found_d) begin
                            idx_q    <= win_idx_d;
                            onehot_q <= win_onehot_d;
                        end else begin
                            state_q  <= IDLE;
                            valid_q  <= 1'b0;
                            idx_q    <= '0;
                            onehot_q <= '0;
                        end
                    end
                end
            endcase
        end
    end

    assign gnt_valid  = valid_q;
    assign gnt_idx    = idx_q;
    assign gnt_onehot = onehot_q;

endmodule

// File: tb/tb_prio_arbiter.sv
// Bench for prio_arbiter (N=8): directed scenarios plus random traffic against a reference model.
module tb_prio_arbiter;

    localparam int N     = 8;
    localparam int IDX_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req;
    logic             gnt_ready;
    logic             gnt_valid;
    logic [IDX_W-1:0] gnt_idx;
    logic [N-1:0]     gnt_onehot;

    int total = 0;
    int bad   = 0;

    prio_arbiter #(.N(N), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .gnt_valid  (gnt_valid),
        .gnt_ready  (gnt_ready),
        .gnt_idx    (gnt_idx),
        .gnt_onehot (gnt_onehot)
    );

    always #5 clk = ~clk;

    // Reference: whenever no grant is pending or the pending one is accepted,
    // pick the next requester by scanning the request vector.
    bit m_valid;
    int m_idx;
    int m_last;
    int cand;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_idx   = 0;
            m_last  = N - 1;
        end else if (!m_valid || gnt_ready) begin
            if (m_valid) m_last = m_idx;
            m_valid = 1'b0;
            m_idx   = 0;
            for (int k = 0; k < N; k++) begin
`ifdef PRIO_ARBITER_RR_EN
                cand = (m_last + 1 + k) % N;
`else
                cand = k;
`endif
                if (!m_valid && req[cand]) begin
                    m_valid = 1'b1;
                    m_idx   = cand;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [N-1:0] e_oh;
        e_oh = m_valid ? (N'(1) << m_idx) : '0;
        chk("model_valid",  32'(gnt_valid),  32'(m_valid));
        chk("model_idx",    32'(gnt_idx),    32'(m_idx));
        chk("model_onehot", 32'(gnt_onehot), 32'(e_oh));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        gnt_ready = 1'b0;
        step();
        step();
        chk("reset_valid",  32'(gnt_valid),  32'd0);
        chk("reset_idx",    32'(gnt_idx),    32'd0);
        chk("reset_onehot", 32'(gnt_onehot), 32'd0);
        rst_n = 1'b1;
        step();
        chk("idle_no_req", 32'(gnt_valid), 32'd0);

`ifdef PRIO_ARBITER_RR_EN
        req       = 8'b1010_0001;
        gnt_ready = 1'b1;
        step(); chk("rr_seq0", 32'(gnt_idx), 32'd0);
        step(); chk("rr_seq5", 32'(gnt_idx), 32'd5);
        step(); chk("rr_seq7", 32'(gnt_idx), 32'd7);
        step(); chk("rr_wrap0", 32'(gnt_idx), 32'd0);
        step(); chk("rr_wrap5", 32'(gnt_idx), 32'd5);
`else
        req = 8'b1010_0000;
        step();
        chk("first_valid",  32'(gnt_valid),  32'd1);
        chk("first_idx",    32'(gnt_idx),    32'd5);
        chk("first_onehot", 32'(gnt_onehot), 32'h20);
        req = 8'b0000_0001;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("hold_idx", 32'(gnt_idx), 32'd5);
        end
        gnt_ready = 1'b1;
        step();
        chk("after_ready_idx", 32'(gnt_idx), 32'd0);
        req = 8'b1000_0011;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("b2b_fixed_idx", 32'(gnt_idx), 32'd0);
        end
`endif
        req       = '0;
        gnt_ready = 1'b1;
        step();
        chk("drain_valid",  32'(gnt_valid),  32'd0);
        chk("drain_idx",    32'(gnt_idx),    32'd0);
        chk("drain_onehot", 32'(gnt_onehot), 32'd0);

        req       = 8'h08;
        gnt_ready = 1'b0;
        step(); chk("pre_rst_idx", 32'(gnt_idx), 32'd3);
        gnt_ready = 1'b1;
        step(); chk("pre_rst_idx2", 32'(gnt_idx), 32'd3);
        gnt_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid",  32'(gnt_valid),  32'd0);
        chk("async_rst_idx",    32'(gnt_idx),    32'd0);
        chk("async_rst_onehot", 32'(gnt_onehot), 32'd0);
        req = 8'hFF;
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_idx",   32'(gnt_idx),   32'd0);
        chk("post_rst_valid", 32'(gnt_valid), 32'd1);

        for (int c = 0; c < 3000; c++) begin
            step();
            case ($urandom % 4)
                0:       req = '0;
                1:       req = N'(1) << ($urandom % N);
                default: req = N'($urandom);
            endcase
            gnt_ready = ($urandom % 3) != 0;
            if ($urandom % 250 == 0) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end

        req       = '0;
        gnt_ready = 1'b1;
        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
